// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream operation handshake plus downstream result/flag handshake.
// Revision 1.0 - initial release.
`default_nettype none

interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_z;
  logic             out_n;
  logic             out_c;
  logic             out_v;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_z, out_n, out_c, out_v
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_z, out_n, out_c, out_v
  );
endinterface

`default_nettype wire

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects the ALU result per op, computes Z/N/C/V, and queues it in a 2-entry skid buffer.
// Revision 1.0 - initial release.
`default_nettype none

module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
);

  localparam int         c_EW   = WIDTH + 4;
  localparam logic [1:0] c_FULL = 2'(DEPTH);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_XOR  = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_ADD  = 3'b100;
  localparam logic [2:0] c_OP_SUB  = 3'b101;
  localparam logic [2:0] c_OP_SLT  = 3'b110;
  localparam logic [2:0] c_OP_PASS = 3'b111;

  logic [c_EW-1:0]  r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic             r_in_ready;
  logic [c_EW-1:0]  r_last;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_v;
  logic             w_sub_v;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_z;
  logic             w_n;
  logic [c_EW-1:0]  w_entry;
  logic [c_EW-1:0]  w_head;
  logic [c_EW-1:0]  w_out;
  logic             w_has_data;
  logic             w_accept;
  logic             w_pop;

  assign w_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
  assign w_diff  = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_v = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) & (w_sum[WIDTH-1]  != bus.in_a[WIDTH-1]);
  assign w_sub_v = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) & (w_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
  // Signed less-than is the true sign of a-b: N corrected by overflow.
  assign w_slt   = w_diff[WIDTH-1] ^ w_sub_v;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.in_op)
      c_OP_AND:  w_res = bus.in_a & bus.in_b;
      c_OP_OR:   w_res = bus.in_a | bus.in_b;
      c_OP_XOR:  w_res = bus.in_a ^ bus.in_b;
      c_OP_NOR:  w_res = ~(bus.in_a | bus.in_b);
      c_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_add_v;
      end
      c_OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = w_sub_v;
      end
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_PASS: w_res = bus.in_b;
      default:   w_res = '0;
    endcase
  end

  assign w_z     = (w_res == '0);
  assign w_n     = w_res[WIDTH-1];
  assign w_entry = {w_res, w_z, w_n, w_c, w_v};

  assign w_has_data = (r_count != 2'd0);
  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_pop      = w_has_data & bus.out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b0;
      r_last     <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < c_FULL);
      if (w_accept) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
      // Track the visible head so the outputs hold their last value once empty.
      if (w_has_data) r_last <= w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];
  assign w_out  = w_has_data ? w_head : r_last;

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = w_has_data;
  assign bus.out_result = w_out[c_EW-1:4];
  assign bus.out_z      = w_out[3];
  assign bus.out_n      = w_out[2];
  assign bus.out_c      = w_out[1];
  assign bus.out_v      = w_out[0];

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage.
// Revision 1.0 - initial release.
`default_nettype none

module tb_alu_result_stage;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(.WIDTH(W), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  // One accept into an empty buffer, check head next cycle, pop, check empty.
  task automatic single_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    bus.out_ready = 1'b0;
    drive(1'b1, op, a, b);
    step();
    bus.in_valid = 1'b0;
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_val({tag, "_result"}, 32'(bus.out_result), 32'(er));
    check_val({tag, "_zncv"}, 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'(ef));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_val({tag, "_popped"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [15:0] bp_a  [3];
  logic [15:0] bp_b  [3];
  logic [2:0]  bp_op [3];
  logic [15:0] bp_exp[3];
  logic [15:0] got_q [$];

  initial begin
    int  idx;
    int  first_pop;
    int  last_pop;
    bit  fire;
    bit  rdy_ok;

    bp_a   = '{16'd1, 16'd0, 16'h5555};
    bp_b   = '{16'd2, 16'd0, 16'h1234};
    bp_op  = '{3'b001, 3'b011, 3'b111};
    bp_exp = '{16'h0003, 16'hFFFF, 16'h1234};

    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_result", 32'(bus.out_result), 32'd0);
    check_val("rst_zncv", 32'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);

    single_op("and",   3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000);
    check_val("and_hold_result", 32'(bus.out_result), 32'h3030);
    single_op("add_ov", 3'b100, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    single_op("add_c",  3'b100, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    single_op("sub",    3'b101, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100);
    single_op("sub_ge", 3'b101, 16'h0005, 16'h0003, 16'h0002, 4'b0010);
    single_op("slt",    3'b110, 16'h8000, 16'h0001, 16'h0001, 4'b0000);
    single_op("slt_f",  3'b110, 16'h0001, 16'h8000, 16'h0000, 4'b1000);
    single_op("xor_z",  3'b010, 16'hA5A5, 16'hA5A5, 16'h0000, 4'b1000);

    // Backpressure: hold downstream for 4 cycles while offering three ops.
    idx = 0;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (idx < 3) drive(1'b1, bp_op[idx], bp_a[idx], bp_b[idx]);
      else         bus.in_valid = 1'b0;
      fire = bus.in_valid & bus.in_ready;
      step();
      if (fire) idx++;
    end
    check_val("bp_accepts", 32'(idx), 32'd2);
    check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("bp_head", 32'(bus.out_result), 32'h0003);
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got_q.size() < 3; cyc++) begin
      if (idx < 3) drive(1'b1, bp_op[idx], bp_a[idx], bp_b[idx]);
      else         bus.in_valid = 1'b0;
      if (bus.out_valid) got_q.push_back(bus.out_result);
      fire = bus.in_valid & bus.in_ready;
      step();
      if (fire) idx++;
    end
    bus.in_valid = 1'b0;
    check_val("bp_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < got_q.size() && i < 3; i++)
      check_val($sformatf("bp_out%0d", i), 32'(got_q[i]), 32'(bp_exp[i]));
    step();
    check_val("bp_drained", 32'(bus.out_valid), 32'd0);

    // Streaming: ten ADDs of i+i with both sides always ready.
    idx = 0; first_pop = -1; last_pop = -1; rdy_ok = 1'b1;
    got_q.delete();
    for (int cyc = 0; cyc < 40 && got_q.size() < 10; cyc++) begin
      if (idx < 10) drive(1'b1, 3'b100, 16'(idx), 16'(idx));
      else          bus.in_valid = 1'b0;
      if (!bus.in_ready) rdy_ok = 1'b0;
      if (bus.out_valid) begin
        got_q.push_back(bus.out_result);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      fire = bus.in_valid & bus.in_ready;
      step();
      if (fire) idx++;
    end
    bus.in_valid = 1'b0;
    check_val("st_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < got_q.size() && i < 10; i++)
      check_val($sformatf("st_out%0d", i), 32'(got_q[i]), 32'(2 * i));
    check_val("st_first", 32'(first_pop), 32'd1);
    check_val("st_span", 32'(last_pop - first_pop), 32'd9);
    check_val("st_ready", 32'(rdy_ok), 32'd1);

    // Asynchronous reset with the buffer full.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b100, 16'h0001, 16'h0001);
    step();
    step();
    bus.in_valid = 1'b0;
    check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("full_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("arst_result", 32'(bus.out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check_val("arel_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("arel_valid0", 32'(bus.out_valid), 32'd0);
    step();
    check_val("arel_valid1", 32'(bus.out_valid), 32'd0);
    check_val("arel_result", 32'(bus.out_result), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream consumer of the 16-bit bitwise units (AND/OR/XOR/NOR) and the adder in the CPU datapath.
- Selects one ALU result per op code and computes condition flags.
- Registers each result and its flags into a 2-entry in-order skid buffer with valid/ready handshakes on both sides.
- Feeds the register-file writeback port and the branch flag logic.

Parameters:
- WIDTH, 16, data width of operands and result.
- DEPTH, 2, skid buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers an operation this cycle.
- in_ready  output  1  stage can accept; equals (count < 2) while rst_n=1; forced 0 while rst_n=0.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (signed), 111 PASS_B.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream consumes the head entry this cycle.
- out_result  output  WIDTH  result of the head entry.
- out_z  output  1  zero flag of the head entry.
- out_n  output  1  negative flag of the head entry.
- out_c  output  1  carry flag of the head entry.
- out_v  output  1  signed-overflow flag of the head entry.

Behaviour:
- Async reset (rst_n=0):
  - count=0, write/read pointers=0, out_valid=0.
  - out_result=0; out_z, out_n, out_c, out_v = 0.
  - in_ready=0.
  - Storage contents are don't-care.
- First rising edge with rst_n=1: in_ready=1.
- Accept and pop:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready at a rising edge.
- Compute is combinational from in_a, in_b, in_op. Result and flags are written into the buffer on accept.
- Latency: an accept into an empty buffer gives out_valid=1 with that entry's data on the next cycle. No combinational path from in_* to out_*.
- out_* always show the head entry. They hold stable while out_valid=1 and out_ready=0. Once a non-pop occurs, the offered data may not change.
- When the buffer is empty, out_valid=0 and out_result/flags hold their last values.
- Ordering is strictly FIFO. Pointers wrap 1 -> 0.
- Count transitions:
  - accept only: count+1.
  - pop only: count-1.
  - both: count unchanged; head advances and the new entry is written.
  - Count 2 with out_ready=1: pop occurs and in_ready is already 0, so no accept that cycle. in_ready rises the following cycle.
  - Count 0 with in_valid=1 and out_ready=1: accept only; no pass-through.
- Arithmetic:
  - ADD: {c, result} = a + b (17-bit).
  - SUB: result = a + ~b + 1; c = 1 when there is no borrow (a >= b unsigned).
  - v for ADD: (a[15]==b[15]) & (result[15]!=a[15]).
  - v for SUB: (a[15]!=b[15]) & (result[15]!=a[15]).
  - SLT: result = 16'h0001 if signed a < b, else 0. Compute it from the SUB sign and overflow (n XOR v).
  - Bitwise ops: per-bit logic. NOR = ~(a | b).
  - PASS_B: result = b.
- Flags:
  - z = (result == 0) and n = result[15] for all ops.
  - c and v are meaningful only for ADD/SUB. They are 0 for every other op, including SLT.
- Illegal conditions:
  - in_valid with in_ready=0: no accept; upstream must hold its data.
  - out_ready while out_valid=0: ignored.
- Reset mid-operation: buffered entries are discarded immediately and out_valid drops asynchronously. No entry reappears after reset.

Test Plan:
- Reset release, then one accept of AND a=16'hF0F0, b=16'h3C3C -> next cycle out_valid=1, result=16'h3030, z=0, n=0, c=0, v=0; out_ready=1 pops it, out_valid=0 the cycle after.
- ADD a=16'h7FFF, b=16'h0001 -> result 16'h8000, n=1, v=1, c=0. ADD a=16'hFFFF, b=16'h0001 -> result 0, z=1, c=1, v=0.
- SUB a=3, b=5 -> result 16'hFFFE, n=1, c=0. SLT a=16'h8000, b=1 -> result 16'h0001, c=0, v=0. XOR a=b=16'hA5A5 -> z=1.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 and ops OR(1,2), NOR(0,0), PASS_B(x,16'h1234) -> two accepts (3 then 16'hFFFF), in_ready=0, the third op is held. Release out_ready -> outputs 3, 16'hFFFF, 16'h1234 in order with no loss or duplication.
- Streaming: in_valid=out_ready=1 continuously for 10 ADDs of i+i -> 1 result/cycle after the 1-cycle fill, values 0, 2, ..., 18; count never exceeds 1.
- Assert rst_n=0 mid-cycle with count=2 -> out_valid=0 and in_ready=0 immediately, out_result=0. After release, no stale entries appear and in_ready=1.
